glyph_pixel_streamer: RTL and testbench
=======================================

# glyph_pixel_streamer

Parametrised digit-glyph source for the display path. It stores a bitmap table of NUM_GLYPHS character glyphs, each GLYPH_W×GLYPH_H pixels, and accepts one glyph request per valid/ready handshake. It then streams that glyph's pixels row-major as a 1-bit pixel stream with backpressure, first/last markers, runtime integer scaling (1×–4×) and optional inversion. It replaces the fixed per-digit 128×1 clocked ROMs with a single table-driven, flow-controlled source for the overlay compositor.

## Interface
- GLYPH_W, default 8: glyph width in pixels.
- GLYPH_H, default 16: glyph height in rows.
- NUM_GLYPHS, default 16: table entries. Codes 0–9 are digits 0–9; the remaining codes are blank.
- CODE_W, default $clog2(NUM_GLYPHS): width of the glyph code.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  a glyph request is presented.
- req_ready  out  1  block is idle and can accept a request.
- req_code  in  CODE_W  glyph index.
- req_scale  in  2  scale minus one (0→1×, 3→4×).
- req_invert  in  1  invert every output pixel.
- out_valid  out  1  out_pix is valid.
- out_ready  in  1  consumer accepts the pixel.
- out_pix  out  1  pixel value (1 = foreground).
- out_first  out  1  first pixel of the glyph.
- out_last  out  1  last pixel of the glyph.

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture code, scale S=req_scale+1 and invert, then go to FETCH.
  - FETCH: issue the row address code*GLYPH_H + src_row to the row ROM. Next state is LOAD.
  - LOAD: load the GLYPH_W-bit ROM data into the row shift register. Next state is STREAM.
  - STREAM: out_valid=1. Each accepted pixel (out_valid&&out_ready) advances a horizontal replicate counter (0..S-1). When that counter wraps, the column advances (0..GLYPH_W-1). At the end of a row:
    - Advance the vertical replicate counter (0..S-1). On its wrap, advance src_row.
    - If more rows remain, go to FETCH.
    - Otherwise go to IDLE.
- Bit order: bit c of row r is column c, emitted left to right starting at c=0. Table address r*GLYPH_W+c matches the legacy per-digit ROM numbering.
- Each request emits GLYPH_W·S × GLYPH_H·S pixels. Every output row re-fetches its source row, including vertical repeats.
- out_pix = table bit XOR invert.
- Codes ≥10 and codes ≥NUM_GLYPHS read as all-zero rows. With invert set they therefore stream all ones.
- out_first is 1 only on the first pixel of the request. out_last is 1 only on the final pixel.
- req_ready is 0 in every state except IDLE. A request presented while busy waits; it is never dropped.

## Timing
- Reset values: req_ready=1, out_valid=0, out_pix=0, out_first=0, out_last=0. FSM goes to IDLE and all counters clear.
- Reset mid-stream aborts the glyph immediately. No out_last is emitted, and the next request starts cleanly.
- Latency: the request is accepted at cycle t. FETCH is at t+1, LOAD at t+2, and the first out_valid is at t+3.
- Each output row costs exactly 2 bubble cycles (FETCH and LOAD), during which out_valid=0.
- Backpressure: while out_valid && !out_ready, out_pix, out_first and out_last hold stable and no counter advances.
- The final pixel is accepted at cycle u. The block is in IDLE with req_ready=1 at u+1. A request accepted at u+1 has its first pixel at u+4.
- Row ROM read is synchronous with one-cycle latency. Data is registered at the LOAD edge.

## Structure
- Package glyph_pkg holds:
  - GLYPH_W and GLYPH_H defaults.
  - Digit bitmap constants for 0–9, as GLYPH_H words of GLYPH_W bits each.
  - The FSM state enum.
- Sub-module glyph_row_rom: synchronous-read ROM of NUM_GLYPHS*GLYPH_H words × GLYPH_W bits. It returns zero for out-of-range codes.
- Counter widths:
  - col: $clog2(GLYPH_W).
  - src_row: $clog2(GLYPH_H).
  - replicate counters: 2 bits each.

## Test plan
- Reset with out_ready=1, then request code 9, scale 0, invert 0 → 128 pixels over 16 rows with one 2-cycle gap between rows. Row 3 = 0,1,1,1,1,0,0,0 and row 4 = 1,1,1,0,1,1,0,0. Rows 0–2 and 12–15 are all 0. out_first on pixel 0, out_last on pixel 127.
- Code 9, scale 1 (2×) → 512 pixels in 32 output rows. Output rows 6 and 7 both = 0,0,1,1,1,1,1,1,1,1,0,0,0,0,0,0.
- Code 12, invert 1 → 128 pixels, all 1.
- Random out_ready toggling (50%) on code 9 → the pixel sequence is identical to the no-stall run, and outputs are stable while stalled.
- Assert reset at pixel 40 of a request → out_valid=0 and req_ready=1 immediately. A following request for code 9 streams from out_first correctly.
- Back-to-back requests (req_valid held high, codes 9 then 0) → second request accepted one cycle after the first's out_last, with its first pixel 3 cycles later.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared constants for the glyph pixel streamer: default glyph geometry,
// the digit bitmaps and the streaming FSM state encoding.
package glyph_pkg;

    localparam int GLYPH_W_DEFAULT = 8;
    localparam int GLYPH_H_DEFAULT = 16;
    localparam int NUM_DIGITS      = 10;

    // Bit c of each word is column c, so bit 0 is the leftmost pixel.
    localparam logic [GLYPH_W_DEFAULT-1:0] DIGIT_ROWS [NUM_DIGITS][GLYPH_H_DEFAULT] = '{
        '{8'h00, 8'h00, 8'h00, 8'h1E, 8'h33, 8'h33, 8'h3B, 8'h37, 8'h33, 8'h33, 8'h33, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h0E, 8'h0F, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h1E, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h33, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h1E, 8'h33, 8'h30, 8'h30, 8'h1C, 8'h30, 8'h30, 8'h33, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h18, 8'h1C, 8'h1A, 8'h19, 8'h3F, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h3F, 8'h03, 8'h03, 8'h1F, 8'h30, 8'h30, 8'h30, 8'h33, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h06, 8'h03, 8'h1F, 8'h33, 8'h33, 8'h33, 8'h33, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h3F, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h1E, 8'h33, 8'h33, 8'h33, 8'h1E, 8'h33, 8'h33, 8'h33, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h1E, 8'h37, 8'h33, 8'h33, 8'h3E, 8'h30, 8'h30, 8'h18, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/glyph_pixel_streamer_rom.sv
// Synchronous-read row ROM holding every glyph row; address is
// code*GLYPH_H + row and anything outside the digit set reads as zero.
module glyph_row_rom
    import glyph_pkg::*;
#(
    parameter int GLYPH_W    = GLYPH_W_DEFAULT,
    parameter int GLYPH_H    = GLYPH_H_DEFAULT,
    parameter int NUM_GLYPHS = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [GLYPH_W-1:0] data
);

    // Widths other than 8 truncate or zero-pad on the right-hand columns.
    function automatic logic [GLYPH_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        int                          code;
        int                          row;
        logic [GLYPH_W_DEFAULT-1:0]  word;
        code = int'(a) / GLYPH_H;
        row  = int'(a) % GLYPH_H;
        word = '0;
        if (code < NUM_GLYPHS && code < NUM_DIGITS && row < GLYPH_H_DEFAULT)
            word = DIGIT_ROWS[code[3:0]][row[3:0]];
        return GLYPH_W'(word);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            data <= '0;
        else
            data <= lookup(addr);
    end

endmodule

// File: rtl/glyph_pixel_streamer.sv
// Table-driven glyph source: accepts one glyph request, then streams its
// pixels row-major with integer scaling, inversion and backpressure.
module glyph_pixel_streamer
    import glyph_pkg::*;
#(
    parameter int GLYPH_W    = GLYPH_W_DEFAULT,
    parameter int GLYPH_H    = GLYPH_H_DEFAULT,
    parameter int NUM_GLYPHS = 16,
    parameter int CODE_W     = $clog2(NUM_GLYPHS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_code,
    input  logic [1:0]        req_scale,
    input  logic              req_invert,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_pix,
    output logic              out_first,
    output logic              out_last
);

    localparam int COL_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int ADDR_W = CODE_W + ROW_W;

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic [1:0]          scale_m1;
    logic                invert;
    logic [1:0]          h_rep;
    logic [1:0]          v_rep;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    src_row;
    logic [GLYPH_W-1:0]  row_bits;
    logic [GLYPH_W-1:0]  shifted;
    logic [GLYPH_W-1:0]  rom_data;
    logic [ADDR_W-1:0]   rom_addr;

    logic                h_wrap;
    logic                row_end;
    logic                last_row;
    logic [1:0]          next_h;
    logic [COL_W-1:0]    next_col;
    logic                next_last;
    logic                load_last;

    assign rom_addr  = ADDR_W'(code) * ADDR_W'(GLYPH_H) + ADDR_W'(src_row);
    assign shifted   = row_bits >> 1;

    assign h_wrap    = (h_rep == scale_m1);
    assign row_end   = h_wrap && (col == COL_W'(GLYPH_W - 1));
    assign last_row  = (v_rep == scale_m1) && (src_row == ROW_W'(GLYPH_H - 1));
    assign next_h    = h_wrap ? 2'd0 : h_rep + 2'd1;
    assign next_col  = h_wrap ? col + COL_W'(1) : col;
    // out_last is registered, so it is computed for the pixel about to be shown.
    assign next_last = last_row && (next_col == COL_W'(GLYPH_W - 1)) && (next_h == scale_m1);
    assign load_last = last_row && (COL_W'(0) == COL_W'(GLYPH_W - 1)) && (scale_m1 == 2'd0);

    glyph_row_rom #(
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H),
        .NUM_GLYPHS (NUM_GLYPHS),
        .ADDR_W     (ADDR_W)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            code      <= '0;
            scale_m1  <= '0;
            invert    <= 1'b0;
            h_rep     <= '0;
            v_rep     <= '0;
            col       <= '0;
            src_row   <= '0;
            row_bits  <= '0;
            req_ready <= 1'b1;
            out_valid <= 1'b0;
            out_pix   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        code      <= req_code;
                        scale_m1  <= req_scale;
                        invert    <= req_invert;
                        h_rep     <= '0;
                        v_rep     <= '0;
                        col       <= '0;
                        src_row   <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    row_bits  <= rom_data;
                    out_valid <= 1'b1;
                    out_pix   <= rom_data[0] ^ invert;
                    out_first <= (src_row == '0) && (v_rep == 2'd0);
                    out_last  <= load_last;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        out_first <= 1'b0;
                        if (row_end) begin
                            h_rep     <= '0;
                            col       <= '0;
                            out_valid <= 1'b0;
                            out_pix   <= 1'b0;
                            out_last  <= 1'b0;
                            if (last_row) begin
                                v_rep     <= '0;
                                src_row   <= '0;
                                req_ready <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                // Vertical repeats re-fetch the same source row.
                                if (v_rep == scale_m1) begin
                                    v_rep   <= '0;
                                    src_row <= src_row + ROW_W'(1);
                                end else begin
                                    v_rep <= v_rep + 2'd1;
                                end
                                state <= ST_FETCH;
                            end
                        end else begin
                            h_rep    <= next_h;
                            col      <= next_col;
                            out_last <= next_last;
                            if (h_wrap) begin
                                row_bits <= shifted;
                                out_pix  <= shifted[0] ^ invert;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Scoreboard bench for glyph_pixel_streamer: a glyph-level reference model
// fills an expected-pixel queue that a negedge monitor drains and compares.
module tb_glyph_pixel_streamer;

    localparam int W  = 8;
    localparam int H  = 16;
    localparam int NG = 16;
    localparam int CW = 4;

    // Drawn rows 3..11 of each digit; every other row is blank.
    localparam logic [7:0] BODY [10][9] = '{
        '{8'h1E, 8'h33, 8'h33, 8'h3B, 8'h37, 8'h33, 8'h33, 8'h33, 8'h1E},
        '{8'h0C, 8'h0E, 8'h0F, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h3F},
        '{8'h1E, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h33, 8'h3F},
        '{8'h1E, 8'h33, 8'h30, 8'h30, 8'h1C, 8'h30, 8'h30, 8'h33, 8'h1E},
        '{8'h18, 8'h1C, 8'h1A, 8'h19, 8'h3F, 8'h18, 8'h18, 8'h18, 8'h3C},
        '{8'h3F, 8'h03, 8'h03, 8'h1F, 8'h30, 8'h30, 8'h30, 8'h33, 8'h1E},
        '{8'h1C, 8'h06, 8'h03, 8'h1F, 8'h33, 8'h33, 8'h33, 8'h33, 8'h1E},
        '{8'h3F, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C},
        '{8'h1E, 8'h33, 8'h33, 8'h33, 8'h1E, 8'h33, 8'h33, 8'h33, 8'h1E},
        '{8'h1E, 8'h37, 8'h33, 8'h33, 8'h3E, 8'h30, 8'h30, 8'h18, 8'h0E}
    };

    typedef struct {
        logic pix;
        logic first;
        logic last;
        logic row_start;
    } pix_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_code;
    logic [1:0]    req_scale;
    logic          req_invert;
    logic          out_valid;
    logic          out_ready;
    logic          out_pix;
    logic          out_first;
    logic          out_last;

    pix_t exp_q[$];
    int   req_cycle_q[$];
    int   n_compared       = 0;
    int   n_mismatched     = 0;
    int   cycle            = 0;
    int   accepted_in_req  = 0;
    int   last_final_cycle = -100;
    bit   stall_mode       = 1'b0;

    glyph_pixel_streamer #(
        .GLYPH_W    (W),
        .GLYPH_H    (H),
        .NUM_GLYPHS (NG),
        .CODE_W     (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_code   (req_code),
        .req_scale  (req_scale),
        .req_invert (req_invert),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pix    (out_pix),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle = cycle + 1;

    // Consumer: always ready, or a fair coin each cycle when stalling is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic model_bit(input int code, input int r, input int c);
        if (code > 9 || r < 3 || r > 11)
            return 1'b0;
        return BODY[4'(code)][4'(r - 3)][3'(c)];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared = n_compared + 1;
        if (actual != expected) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Expected stream: every output pixel maps back to source pixel (row/S, col/S).
    task automatic pushModel(input int code, input int scale_m1, input bit inv);
        int   s;
        int   total;
        int   idx;
        pix_t e;
        s     = scale_m1 + 1;
        total = W * s * H * s;
        idx   = 0;
        for (int orow = 0; orow < H * s; orow++) begin
            for (int ocol = 0; ocol < W * s; ocol++) begin
                e.pix       = model_bit(code, orow / s, ocol / s) ^ inv;
                e.first     = (idx == 0);
                e.last      = (idx == total - 1);
                e.row_start = (ocol == 0);
                exp_q.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic applyStimulus(input int code, input int scale_m1, input bit inv, output int acc_cycle);
        int budget;
        budget = 30000;
        @(negedge clock);
        req_code   = CW'(code);
        req_scale  = 2'(scale_m1);
        req_invert = inv;
        req_valid  = 1'b1;
        while (!req_ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checkOutput("req_accepted", int'(req_ready), 1);
        acc_cycle = cycle;
        accepted_in_req = 0;
        pushModel(code, scale_m1, inv);
        req_cycle_q.push_back(cycle);
        @(posedge clock);
        #1;
    endtask

    task automatic waitIdle(input string label);
        int budget;
        budget = 30000;
        while ((exp_q.size() != 0 || !req_ready) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checkOutput({label, "_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: compares every accepted pixel, stall stability and row/request timing.
    initial begin
        pix_t e;
        bit   prev_valid;
        bit   prev_ready;
        bit   prev_pix;
        bit   prev_first;
        bit   prev_last;
        bit   check_ready_next;
        int   rise_cycle;
        int   prev_accept_cycle;
        int   req_at;
        prev_valid        = 1'b0;
        prev_ready        = 1'b0;
        prev_pix          = 1'b0;
        prev_first        = 1'b0;
        prev_last         = 1'b0;
        check_ready_next  = 1'b0;
        rise_cycle        = 0;
        prev_accept_cycle = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_valid       = 1'b0;
                check_ready_next = 1'b0;
                continue;
            end
            if (check_ready_next) begin
                checkOutput("ready_after_last", int'(req_ready), 1);
                check_ready_next = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("stall_valid", int'(out_valid), 1);
                checkOutput("stall_pix", int'(out_pix), int'(prev_pix));
                checkOutput("stall_first", int'(out_first), int'(prev_first));
                checkOutput("stall_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && !prev_valid)
                rise_cycle = cycle;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pix", int'(out_pix), int'(e.pix));
                    checkOutput("first", int'(out_first), int'(e.first));
                    checkOutput("last", int'(out_last), int'(e.last));
                    if (e.row_start) begin
                        if (e.first) begin
                            req_at = (req_cycle_q.size() != 0) ? req_cycle_q.pop_front() : -100;
                            checkOutput("first_latency", rise_cycle - req_at, 3);
                        end else begin
                            checkOutput("row_bubble", rise_cycle - prev_accept_cycle, 3);
                        end
                    end
                    if (e.last) begin
                        last_final_cycle = cycle;
                        check_ready_next = 1'b1;
                    end
                    accepted_in_req   = accepted_in_req + 1;
                    prev_accept_cycle = cycle;
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_pix   = out_pix;
            prev_first = out_first;
            prev_last  = out_last;
        end
    end

    initial begin
        int acc;
        int acc2;
        int budget;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_code   = '0;
        req_scale  = 2'd0;
        req_invert = 1'b0;
        #1;
        checkOutput("reset_req_ready", int'(req_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_pix", int'(out_pix), 0);
        checkOutput("reset_out_first", int'(out_first), 0);
        checkOutput("reset_out_last", int'(out_last), 0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;

        $display("[TB] code 9 at 1x, 2x, then blank code 12 inverted");
        applyStimulus(9, 0, 1'b0, acc);
        req_valid = 1'b0;
        waitIdle("code9_x1");
        applyStimulus(9, 1, 1'b0, acc);
        req_valid = 1'b0;
        waitIdle("code9_x2");
        applyStimulus(12, 0, 1'b1, acc);
        req_valid = 1'b0;
        waitIdle("code12_inv");

        $display("[TB] random backpressure and random requests");
        stall_mode = 1'b1;
        applyStimulus(9, 0, 1'b0, acc);
        req_valid = 1'b0;
        waitIdle("code9_stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(int'($urandom_range(0, NG - 1)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), acc);
            req_valid = 1'b0;
            waitIdle("random_req");
        end
        stall_mode = 1'b0;

        $display("[TB] reset in the middle of a glyph");
        applyStimulus(9, 0, 1'b0, acc);
        req_valid = 1'b0;
        budget = 2000;
        while (accepted_in_req < 40 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checkOutput("abort_reached_pixel40", int'(accepted_in_req >= 40), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_req_ready", int'(req_ready), 1);
        checkOutput("abort_out_last", int'(out_last), 0);
        exp_q.delete();
        req_cycle_q.delete();
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        applyStimulus(9, 0, 1'b0, acc);
        req_valid = 1'b0;
        waitIdle("after_abort");

        $display("[TB] back-to-back requests with req_valid held");
        applyStimulus(9, 0, 1'b0, acc);
        applyStimulus(0, 0, 1'b0, acc2);
        req_valid = 1'b0;
        checkOutput("b2b_accept_gap", acc2 - last_final_cycle, 1);
        checkOutput("b2b_order", int'(acc2 > acc), 1);
        waitIdle("b2b");

        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
